// File: rtl/veda_loader.sv
// rtl/veda_loader.sv - streams an image into memory port 2, reads it back to verify
// a checksum and holds the processor until the image is good.
module veda_loader #(
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic             mem_mode,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_data_in,
    input  logic [31:0]      mem_data_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_VERIFY = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]        state;
    logic [31:0]       base_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  rd_idx;
    logic [31:0]       wsum;
    logic [31:0]       rsum;
    // tag[k] marks a read launched k edges ago; tag[READ_LAT] means data_out is valid now
    logic [READ_LAT:0] tag;

    assign s_ready = (state == ST_WRITE) && (wr_idx < count_q);
    assign busy    = (state == ST_WRITE) || (state == ST_VERIFY) || (state == ST_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            wsum        <= '0;
            rsum        <= '0;
            tag         <= '0;
            mem_mode    <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_hold    <= 1'b1;
        end else begin
            tag[0] <= 1'b0;
            for (int k = 1; k <= READ_LAT; k++) begin
                tag[k] <= tag[k-1];
            end
            if (tag[READ_LAT]) begin
                rsum <= rsum + mem_data_out;
            end
            mem_mode <= 1'b0;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= word_count;
                        wr_idx  <= '0;
                        rd_idx  <= '0;
                        wsum    <= '0;
                        rsum    <= '0;
                        error   <= 1'b0;
                        if (word_count == '0) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= ST_WRITE;
                            done     <= 1'b0;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (s_valid && s_ready) begin
                        mem_mode    <= 1'b1;
                        mem_address <= base_q + 32'(wr_idx);
                        mem_data_in <= s_data;
                        wsum        <= wsum + s_data;
                        wr_idx      <= wr_idx + 1'b1;
                    end else if (wr_idx == count_q) begin
                        // the edge that retires the last write also launches read 0
                        state       <= ST_VERIFY;
                        mem_address <= base_q;
                        rd_idx      <= {{(CNT_W-1){1'b0}}, 1'b1};
                        tag[0]      <= 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (rd_idx == count_q) begin
                        state <= ST_WAIT;
                    end else begin
                        mem_address <= base_q + 32'(rd_idx);
                        rd_idx      <= rd_idx + 1'b1;
                        tag[0]      <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (tag == '0) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        error    <= (rsum != wsum);
                        cpu_hold <= (rsum != wsum);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_veda_loader.sv
// tb/tb_veda_loader.sv - scoreboard bench for veda_loader with a registered-read memory model.
module tb_veda_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        mem_mode;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    veda_loader #(.READ_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_mode(mem_mode), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy),
        .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];

    always @(posedge clk) begin
        if (mem_mode) mem[mem_address] = mem_data_in;
        mem_data_out <= mem.exists(mem_address) ? mem[mem_address] : 32'h0;
    end

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct { int rel; logic err; logic hold; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    logic [31:0] words[$];
    logic [31:0] cur_base;
    int start_edge = 0;
    int checks = 0;
    int errors = 0;
    logic done_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // monitor: every write cycle and every done rise pops one expectation
    always @(negedge clk) begin
        if (!rst) begin
            done_d = 1'b0;
        end else begin
            if (mem_mode) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h required none", mem_address, mem_data_in);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_addr", mem_address, w.a);
                    chk("write_data", mem_data_in, w.d);
                end
            end
            if (done && !done_d) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at edge %0d required none", edge_n - start_edge + 1);
                end else begin
                    dn_t e;
                    e = dq.pop_front();
                    chk("done_edge", 32'(edge_n - start_edge + 1), 32'(e.rel));
                    chk("done_error", {31'b0, error}, {31'b0, e.err});
                    chk("done_cpu_hold", {31'b0, cpu_hold}, {31'b0, e.hold});
                end
            end
            done_d = done;
        end
    end

    task automatic do_start(input logic [31:0] b, input int n);
        @(negedge clk);
        base_addr  = b;
        word_count = 16'(n);
        cur_base   = b;
        start      = 1'b1;
        start_edge = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int stop, input bit stall);
        int k = 0;
        int cyc = 0;
        while (k < stop && cyc < 200) begin
            s_valid = !(stall && cyc[0]);
            s_data  = words[k];
            if (s_valid && s_ready) begin
                wq.push_back('{a: cur_base + 32'(k), d: words[k]});
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        chk("feed_timeout", 32'(k), 32'(stop));
    endtask

    task automatic wait_done();
        int t = 0;
        bit bad = 0;
        while (!done && t < 100) begin
            if (s_ready) bad = 1;
            @(negedge clk);
            t++;
        end
        chk("done_timeout", {31'b0, t < 100}, 32'h1);
        chk("s_ready_after_last", {31'b0, bad}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        s_valid = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", {31'b0, s_ready}, 0);
        chk("rst_mem_mode", {31'b0, mem_mode}, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_cpu_hold", {31'b0, cpu_hold}, 1);
        rst = 1'b1;

        // zero count: done on the start edge, no writes
        dq.push_back('{rel: 1, err: 1'b0, hold: 1'b0});
        do_start(32'h0, 0);
        wait_done();

        // basic
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        dq.push_back('{rel: 12, err: 1'b0, hold: 1'b0});
        do_start(32'h0, 4);
        feed(4, 0);
        wait_done();
        for (int i = 0; i < 4; i++) chk("basic_mem", mrd(32'(i)), words[i]);

        // stalls on alternate cycles: three extra edges
        foreach (words[i]) mem[32'(i)] = 32'h0;
        dq.push_back('{rel: 15, err: 1'b0, hold: 1'b0});
        do_start(32'h0, 4);
        feed(4, 1);
        wait_done();
        for (int i = 0; i < 4; i++) chk("stall_mem", mrd(32'(i)), words[i]);

        // corruption of word 2 after its write, before its read
        dq.push_back('{rel: 12, err: 1'b1, hold: 1'b1});
        do_start(32'h0, 4);
        feed(4, 0);
        mem[32'h2] = 32'h0;
        wait_done();
        chk("corrupt_error_level", {31'b0, error}, 1);
        do_start(32'h0, 0);
        chk("restart_error_cleared", {31'b0, error}, 0);
        chk("restart_cpu_hold", {31'b0, cpu_hold}, 0);

        // reset mid-load
        words = {};
        for (int i = 0; i < 8; i++) words.push_back(32'h100 + 32'(i));
        do_start(32'h10, 8);
        feed(2, 0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_mode", {31'b0, mem_mode}, 0);
        chk("midrst_mem_address", mem_address, 0);
        chk("midrst_mem_data_in", mem_data_in, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_s_ready", {31'b0, s_ready}, 0);
        chk("midrst_cpu_hold", {31'b0, cpu_hold}, 1);
        @(negedge clk);
        rst = 1'b1;
        dq.push_back('{rel: 20, err: 1'b0, hold: 1'b0});
        do_start(32'h10, 8);
        feed(8, 0);
        wait_done();
        for (int i = 0; i < 8; i++) chk("rerun_mem", mrd(32'h10 + 32'(i)), words[i]);

        // address and checksum wrap, with a start pulse ignored during VERIFY
        words = '{32'hFFFF_FFFF, 32'h2, 32'h10};
        dq.push_back('{rel: 10, err: 1'b0, hold: 1'b0});
        do_start(32'hFFFF_FFFE, 3);
        feed(3, 0);
        @(negedge clk);
        base_addr = 32'h0; word_count = 16'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("wrap_mem_fffffffe", mrd(32'hFFFF_FFFE), 32'hFFFF_FFFF);
        chk("wrap_mem_ffffffff", mrd(32'hFFFF_FFFF), 32'h2);
        chk("wrap_mem_0", mrd(32'h0), 32'h10);

        chk("write_queue_empty", 32'(wq.size()), 0);
        chk("done_queue_empty", 32'(dq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
